// File: rtl/snn_pkg.sv
// Shared defaults and helpers for the spiking-neuron datapath (synaptic stage and LIF neuron).
package snn_pkg;

   localparam int DEF_I_WIDTH   = 8;
   localparam int DEF_W_WIDTH   = 8;
   localparam int DEF_TAU_SHIFT = 2;
   localparam logic [DEF_W_WIDTH-1:0] DEF_WEIGHT_INIT = 8'd16;

   // Unsigned add that clamps at all-ones instead of wrapping.
   function automatic logic [DEF_I_WIDTH-1:0] satAdd(input logic [DEF_I_WIDTH-1:0] a,
                                                     input logic [DEF_I_WIDTH-1:0] b);
      logic [DEF_I_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DEF_I_WIDTH] ? '1 : s[DEF_I_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/synapse_weight_bank.sv
// Per-input synaptic weight register file: synchronous write, all weights readable at once.
module synapse_weight_bank
   import snn_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int W_WIDTH = DEF_W_WIDTH,
   parameter logic [W_WIDTH-1:0] WEIGHT_INIT = W_WIDTH'(DEF_WEIGHT_INIT),
   localparam int A_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wr_en_i,
   input  logic [A_WIDTH-1:0]            wr_addr_i,
   input  logic [W_WIDTH-1:0]            wr_data_i,
   output logic [N_IN-1:0][W_WIDTH-1:0]  weights_o
);

   logic [N_IN-1:0][W_WIDTH-1:0] weights_q;

   // An address matching no entry simply selects nothing, so out-of-range writes vanish.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         weights_q <= {N_IN{WEIGHT_INIT}};
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (wr_en_i && (wr_addr_i == A_WIDTH'(i))) begin
               weights_q[i] <= wr_data_i;
            end
         end
      end
   end

   assign weights_o = weights_q;

endmodule

// File: rtl/synaptic_current_gen.sv
// Turns presynaptic spikes into the neuron's synaptic current: weighted sum, shift decay, clamp.
module synaptic_current_gen
   import snn_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int W_WIDTH = DEF_W_WIDTH,
   parameter int I_WIDTH = DEF_I_WIDTH,
   parameter int TAU_SHIFT = DEF_TAU_SHIFT,
   parameter logic [W_WIDTH-1:0] WEIGHT_INIT = W_WIDTH'(DEF_WEIGHT_INIT),
   localparam int A_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_IN-1:0]    spike_in,
   input  logic               clear,
   input  logic               wr_en,
   input  logic [A_WIDTH-1:0] wr_addr,
   input  logic [W_WIDTH-1:0] wr_data,
   output logic [I_WIDTH-1:0] Isyn,
   output logic               sat
);

   localparam int SUM_W = W_WIDTH + $clog2(N_IN);
   localparam int CMP_W = (SUM_W > I_WIDTH) ? SUM_W : I_WIDTH;
   localparam logic [I_WIDTH-1:0] I_MAX = '1;

   logic [N_IN-1:0][W_WIDTH-1:0] weights;
   logic [N_IN-1:0]    spk_q;
   logic [I_WIDTH-1:0] sum_q, sum_d;
   logic               sumSat_q, sumSat_d;
   logic [I_WIDTH-1:0] isyn_q, isyn_d;
   logic               sat_q, sat_d;

   logic [SUM_W-1:0]   sumWide;
   logic [CMP_W-1:0]   sumExt;
   logic [I_WIDTH-1:0] shifted;
   logic [I_WIDTH-1:0] dec;
   logic [I_WIDTH-1:0] decayed;
   logic [I_WIDTH:0]   nxt;

   synapse_weight_bank #(
      .N_IN        (N_IN),
      .W_WIDTH     (W_WIDTH),
      .WEIGHT_INIT (WEIGHT_INIT)
   ) u_weights (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .weights_o (weights)
   );

   // Full-width sum of the active weights, clamped only once every term is in.
   always_comb begin
      sumWide = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (spk_q[i]) begin
            sumWide = sumWide + SUM_W'(weights[i]);
         end
      end
      sumExt   = CMP_W'(sumWide);
      sumSat_d = (sumExt > CMP_W'(I_MAX));
      sum_d    = sumSat_d ? I_MAX : sumExt[I_WIDTH-1:0];
   end

   // A nonzero current always loses at least 1, so small values cannot stall above 0.
   always_comb begin
      shifted = isyn_q >> TAU_SHIFT;
      if (shifted != '0) begin
         dec = shifted;
      end else begin
         dec = (isyn_q != '0) ? I_WIDTH'(1) : '0;
      end
      decayed = isyn_q - dec;
      nxt     = {1'b0, decayed} + {1'b0, sum_q};
      isyn_d  = nxt[I_WIDTH] ? I_MAX : nxt[I_WIDTH-1:0];
      sat_d   = sumSat_q || nxt[I_WIDTH];
   end

   // Reset and clear both flush the whole pipeline; only reset touches the weights.
   always_ff @(posedge clk) begin
      if (rst_n || clear) begin
         spk_q    <= '0;
         sum_q    <= '0;
         sumSat_q <= 1'b0;
         isyn_q   <= '0;
         sat_q    <= 1'b0;
      end else begin
         spk_q    <= spike_in;
         sum_q    <= sum_d;
         sumSat_q <= sumSat_d;
         isyn_q   <= isyn_d;
         sat_q    <= sat_d;
      end
   end

   assign Isyn = isyn_q;
   assign sat  = sat_q;

endmodule

// File: tb/tb_synaptic_current_gen.sv
// Directed bench for synaptic_current_gen with a cycle-history reference model.
module tb_synaptic_current_gen;

   localparam int HIST = 4096;

   logic       clk;
   logic       rst_n;
   logic [3:0] spike_in;
   logic       clear;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] Isyn;
   logic       sat;

   int compared   = 0;
   int mismatched = 0;

   synaptic_current_gen dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spike_in (spike_in),
      .clear    (clear),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .Isyn     (Isyn),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remembers every cycle's spikes, flushes and weights, then derives
   // the current from the arithmetic rules (spike in cycle c-2, weight seen in cycle c-1).
   logic [3:0] spkHist   [0:HIST-1];
   bit         flushHist [0:HIST-1];
   int         wHist     [0:HIST-1][0:3];
   int         mW [0:3];
   int         mIsyn = 0;
   bit         mSat = 1'b0;
   bit         modelReady = 1'b0;
   int         cyc = 0;
   int         raw, nxtVal, decVal, sumVal;

   always @(posedge clk) begin
      if (cyc < HIST) begin
         spkHist[cyc]   = spike_in;
         flushHist[cyc] = rst_n || clear;
         for (int i = 0; i < 4; i++) wHist[cyc][i] = mW[i];
         if (rst_n) begin
            mIsyn = 0;
            mSat  = 1'b0;
            for (int i = 0; i < 4; i++) mW[i] = 16;
         end else begin
            raw = 0;
            if (cyc >= 2 && !flushHist[cyc-2] && !flushHist[cyc-1]) begin
               for (int i = 0; i < 4; i++)
                  if (spkHist[cyc-2][i]) raw += wHist[cyc-1][i];
            end
            if (clear) begin
               mIsyn = 0;
               mSat  = 1'b0;
            end else begin
               decVal = mIsyn / 4;
               if (decVal == 0 && mIsyn > 0) decVal = 1;
               sumVal = (raw > 255) ? 255 : raw;
               nxtVal = mIsyn - decVal + sumVal;
               mSat   = (raw > 255) || (nxtVal > 255);
               mIsyn  = (nxtVal > 255) ? 255 : nxtVal;
            end
            if (wr_en) mW[wr_addr] = int'(wr_data);
         end
         modelReady = 1'b1;
         cyc++;
      end
   end

   // Every cycle after the first edge the outputs are meaningful and must match the model.
   always @(negedge clk) begin
      if (modelReady) begin
         compared++;
         if (int'(Isyn) != mIsyn || sat != mSat) begin
            mismatched++;
            $display("[TB] FAIL model_cycle%0d: Isyn=%0d sat=%0d, expected Isyn=%0d sat=%0d",
                     cyc, Isyn, sat, mIsyn, mSat);
         end
      end
   end

   // Drives one cycle's inputs, then advances to just after the next rising edge.
   task automatic applyStimulus(input logic [3:0] spk, input logic clr, input logic we,
                                input logic [1:0] addr, input logic [7:0] data,
                                input logic rst);
      spike_in = spk;
      clear    = clr;
      wr_en    = we;
      wr_addr  = addr;
      wr_data  = data;
      rst_n    = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int expIsyn, input bit expSat);
      compared++;
      if (int'(Isyn) != expIsyn || sat != expSat) begin
         mismatched++;
         $display("[TB] FAIL %s: Isyn=%0d sat=%0d, expected Isyn=%0d sat=%0d",
                  name, Isyn, sat, expIsyn, expSat);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
   endtask

   int         decayExp [0:15] = '{0, 0, 0, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
   logic [3:0] vec;

   initial begin
      spike_in = '0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rst_n = 1'b1;
      applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);

      $display("[TB] reset and default weights");
      for (int k = 0; k < 3; k++) begin
         checkOutput("reset_idle", 0, 1'b0);
         idle(1);
      end
      for (int inp = 0; inp < 4; inp++) begin
         vec = 4'(1 << inp);
         for (int k = 0; k < 14; k++) begin
            if (k == 3) checkOutput($sformatf("init_weight%0d", inp), 16, 1'b0);
            applyStimulus((k == 0) ? vec : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
         end
      end

      $display("[TB] single pulse latency and decay floor");
      for (int k = 0; k < 16; k++) begin
         checkOutput($sformatf("decay_c%0d", k), decayExp[k], 1'b0);
         applyStimulus((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      $display("[TB] simultaneous spikes clamp in the adder");
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b1, 2'(i), 8'd100, 1'b0);
      idle(2);
      for (int k = 0; k < 30; k++) begin
         if (k == 3) checkOutput("sum_clamp", 255, 1'b1);
         if (k == 4) checkOutput("sum_clamp_decay", 192, 1'b0);
         applyStimulus((k == 0) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      $display("[TB] write racing the adder sees the old weight");
      applyStimulus(4'b0000, 1'b0, 1'b1, 2'd2, 8'd16, 1'b0);
      idle(2);
      for (int k = 0; k < 21; k++) begin
         if (k == 3) checkOutput("wr_race_old", 16, 1'b0);
         applyStimulus((k == 0) ? 4'b0100 : 4'b0000, 1'b0, (k == 1), 2'd2, 8'd40, 1'b0);
      end
      for (int k = 0; k < 21; k++) begin
         if (k == 3) checkOutput("wr_race_new", 40, 1'b0);
         applyStimulus((k == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      $display("[TB] accumulation clamps at the output stage");
      applyStimulus(4'b0000, 1'b0, 1'b1, 2'd0, 8'd120, 1'b0);
      idle(2);
      for (int k = 0; k < 40; k++) begin
         if (k == 3) checkOutput("accum_c3", 120, 1'b0);
         if (k == 4) checkOutput("accum_c4", 210, 1'b0);
         if (k == 5) checkOutput("accum_sat_c5", 255, 1'b1);
         if (k == 6) checkOutput("accum_sat_c6", 255, 1'b1);
         if (k == 7) checkOutput("accum_c7", 192, 1'b0);
         applyStimulus((k < 4) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      $display("[TB] clear flushes in-flight spikes, concurrent write applies");
      for (int k = 0; k < 11; k++) begin
         if (k == 3) checkOutput("pre_clear", 120, 1'b0);
         if (k >= 4) checkOutput($sformatf("post_clear_c%0d", k), 0, 1'b0);
         vec = (k == 0) ? 4'b0001 : ((k <= 3) ? 4'b0010 : 4'b0000);
         applyStimulus(vec, (k == 3), (k == 3), 2'd1, 8'd50, 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         if (k == 3) checkOutput("clear_write_applied", 50, 1'b0);
         applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         if (k == 3) checkOutput("clear_kept_weight", 120, 1'b0);
         applyStimulus((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      end

      $display("[TB] reset mid-decay restores weights");
      applyStimulus(4'b0000, 1'b0, 1'b1, 2'd3, 8'd200, 1'b0);
      idle(2);
      for (int k = 0; k < 20; k++) begin
         if (k == 3)  checkOutput("pre_reset", 200, 1'b0);
         if (k == 6)  checkOutput("post_reset", 0, 1'b0);
         if (k == 11) checkOutput("reset_weights", 32, 1'b0);
         if (k == 12) checkOutput("reset_weights_decay", 24, 1'b0);
         vec = (k == 0) ? 4'b1000 : ((k == 8) ? 4'b1001 : 4'b0000);
         applyStimulus(vec, 1'b0, 1'b0, 2'd0, 8'd0, (k == 5));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
